// File: rtl/fp32_pkg.sv
// Shared definitions for the binary32 adder datapath.
//   EXP_W / MAN_W / BIAS : binary32 field widths and exponent bias
//   EXP_MAX              : all-ones exponent (Inf/NaN encoding, overflow limit)
//   QNAN / POS_INF / NEG_INF : canonical special results
//   fp_unpk_t / fp_unpack    : operand split into sign, exponent and significand
//                              with the hidden bit, plus class flags
package fp32_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int BIAS  = 127;

   localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;
   localparam logic [31:0] NEG_INF = 32'hFF80_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W:0]   man;
      logic             is_zero;
      logic             is_inf;
      logic             is_nan;
   } fp_unpk_t;

   // Subnormals are flushed to signed zero: a zero exponent always yields a
   // zero significand, so the rest of the datapath never sees a denormal.
   function automatic fp_unpk_t fp_unpack(input logic [31:0] x);
      fp_unpk_t         u;
      logic [EXP_W-1:0] e;
      logic [MAN_W-1:0] f;
      e         = x[30:23];
      f         = x[22:0];
      u.sign    = x[31];
      u.exp     = e;
      u.is_nan  = (e == EXP_MAX) && (f != '0);
      u.is_inf  = (e == EXP_MAX) && (f == '0);
      u.is_zero = (e == '0);
      u.man     = u.is_zero ? '0 : {1'b1, f};
      return u;
   endfunction

endpackage

// File: rtl/fp32_adder_if.sv
// Operand/result bundle of the binary32 adder.
//   in_valid, a, b : operand pair, driven by the master
//   out_valid, sum : result, driven by the adder (slave)
interface fp32_adder_if;

   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic [31:0] sum;

   modport master (
      output in_valid, a, b,
      input  out_valid, sum
   );

   modport slave (
      input  in_valid, a, b,
      output out_valid, sum
   );

endinterface

// File: rtl/fp32_lzc.sv
// Leading-zero counter for the 28-bit post-add magnitude.
//   x   : value to scan (bit 27 is the MSB)
//   cnt : number of zeros above the highest set bit, 28 when x is zero
module fp32_lzc (
   input  logic [27:0] x,
   output logic [4:0]  cnt
);

   // Ascending scan: the last hit is the highest set bit.
   always_comb begin
      cnt = 5'd28;
      for (int i = 0; i < 28; i++) begin
         if (x[i]) cnt = 5'(27 - i);
      end
   end

endmodule

// File: rtl/fp32_adder.sv
// Pipelined binary32 adder, round-to-nearest-even, DAZ/FTZ.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, drops every in-flight operation
//   bus   : slave side of fp32_adder_if (in_valid/a/b in, out_valid/sum out)
// An operand pair captured on edge k produces out_valid/sum after edge k+3:
//   edge k   : operand capture
//   edge k+1 : unpack, specials, magnitude ordering, alignment
//   edge k+2 : add/subtract and normalize
//   edge k+3 : round and pack
// sum holds its last value whenever out_valid is low.
module fp32_adder #(
   parameter int LATENCY = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   fp32_adder_if.slave bus
);

   import fp32_pkg::*;

   logic [LATENCY-1:0] vld;

   // ---------------- operand capture ----------------
   logic [31:0] r0_a;
   logic [31:0] r0_b;

   always_ff @(posedge clk) begin
      if (bus.in_valid) begin
         r0_a <= bus.a;
         r0_b <= bus.b;
      end
   end

   // ---------------- stage 1: unpack / order / align ----------------
   fp_unpk_t         ua;
   fp_unpk_t         ub;
   logic             swap;
   logic             l_sign;
   logic [EXP_W-1:0] l_exp;
   logic [MAN_W:0]   l_man;
   logic [EXP_W-1:0] s_exp;
   logic [MAN_W:0]   s_man;
   logic             s_zero;
   logic [EXP_W-1:0] diff;
   logic [52:0]      sh_ext;
   logic [26:0]      s_align;
   logic             c1_special;
   logic [31:0]      c1_sval;

   always_comb begin
      ua     = fp_unpack(r0_a);
      ub     = fp_unpack(r0_b);
      swap   = {ub.exp, ub.man} > {ua.exp, ua.man};
      l_sign = swap ? ub.sign : ua.sign;
      l_exp  = swap ? ub.exp  : ua.exp;
      l_man  = swap ? ub.man  : ua.man;
      s_exp  = swap ? ua.exp  : ub.exp;
      s_man  = swap ? ua.man  : ub.man;
      s_zero = swap ? ua.is_zero : ub.is_zero;
      diff   = l_exp - s_exp;

      // Significand plus G/R/S slots, followed by 26 catch bits that feed sticky.
      sh_ext = {s_man, 29'b0} >> diff;
      if (s_zero) begin
         s_align = '0;
      end else if (diff >= 8'd26) begin
         s_align = 27'd1;
      end else begin
         s_align = {sh_ext[52:27], sh_ext[26] | (|sh_ext[25:0])};
      end

      c1_special = 1'b1;
      c1_sval    = QNAN;
      if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != ub.sign))) begin
         c1_sval = QNAN;
      end else if (ua.is_inf) begin
         c1_sval = ua.sign ? NEG_INF : POS_INF;
      end else if (ub.is_inf) begin
         c1_sval = ub.sign ? NEG_INF : POS_INF;
      end else begin
         c1_special = 1'b0;
      end
   end

   logic             s1_special;
   logic [31:0]      s1_sval;
   logic             s1_sign;
   logic             s1_sub;
   logic [EXP_W-1:0] s1_exp;
   logic [26:0]      s1_man_l;
   logic [26:0]      s1_man_s;

   always_ff @(posedge clk) begin
      if (vld[0]) begin
         s1_special <= c1_special;
         s1_sval    <= c1_sval;
         s1_sign    <= l_sign;
         s1_sub     <= ua.sign ^ ub.sign;
         s1_exp     <= l_exp;
         s1_man_l   <= {l_man, 3'b000};
         s1_man_s   <= s_align;
      end
   end

   // ---------------- stage 2: add / normalize ----------------
   logic [27:0] raw;
   logic [4:0]  lz;
   logic [4:0]  lsh;
   logic [26:0] norm;
   logic [9:0]  exp_n;
   logic        c2_zero;
   logic        c2_sign;

   fp32_lzc u_lzc (
      .x   (raw),
      .cnt (lz)
   );

   always_comb begin
      // Operands are ordered by magnitude, so the subtraction never goes negative.
      raw = s1_sub ? ({1'b0, s1_man_l} - {1'b0, s1_man_s})
                   : ({1'b0, s1_man_l} + {1'b0, s1_man_s});
      lsh = lz - 5'd1;
      if (raw[27]) begin
         norm  = {raw[27:2], raw[1] | raw[0]};
         exp_n = {2'b00, s1_exp} + 10'd1;
      end else begin
         norm  = raw[26:0] << lsh;
         exp_n = {2'b00, s1_exp} - {5'b00000, lsh};
      end
      // A zero sum keeps the common sign only when both operands agreed in sign;
      // true cancellation always gives +0.
      c2_zero = (raw == '0);
      c2_sign = c2_zero ? (s1_sign & ~s1_sub) : s1_sign;
   end

   logic        s2_special;
   logic [31:0] s2_sval;
   logic        s2_zero;
   logic        s2_sign;
   logic [9:0]  s2_exp;
   logic [26:0] s2_man;

   always_ff @(posedge clk) begin
      if (vld[1]) begin
         s2_special <= s1_special;
         s2_sval    <= s1_sval;
         s2_zero    <= c2_zero;
         s2_sign    <= c2_sign;
         s2_exp     <= exp_n;
         s2_man     <= norm;
      end
   end

   // ---------------- stage 3: round / pack ----------------
   logic        rnd;
   logic [24:0] m_r;
   logic [9:0]  exp_f;
   logic [22:0] frac;
   logic [31:0] res;

   always_comb begin
      rnd   = s2_man[2] & (s2_man[1] | s2_man[0] | s2_man[3]);
      m_r   = {1'b0, s2_man[26:3]} + 25'(rnd);
      exp_f = s2_exp + {9'b0, m_r[24]};
      frac  = m_r[24] ? m_r[23:1] : m_r[22:0];

      // Range checks follow rounding so a carry into the min-normal exponent
      // survives FTZ and a carry into EXP_MAX becomes Inf.
      if (s2_special) begin
         res = s2_sval;
      end else if (s2_zero || exp_f[9] || (exp_f == '0)) begin
         res = {s2_sign, 31'b0};
      end else if (exp_f >= {2'b00, EXP_MAX}) begin
         res = s2_sign ? NEG_INF : POS_INF;
      end else begin
         res = {s2_sign, exp_f[7:0], frac};
      end
   end

   // ---------------- valid pipeline and output register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld           <= '0;
         bus.out_valid <= 1'b0;
         bus.sum       <= '0;
      end else begin
         vld           <= {vld[LATENCY-2:0], bus.in_valid};
         bus.out_valid <= vld[LATENCY-1];
         if (vld[LATENCY-1]) bus.sum <= res;
      end
   end

endmodule

// File: tb/tb_fp32_adder.sv
`timescale 1ns/1ps
module tb_fp32_adder;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fp32_adder_if bus ();

   fp32_adder #(.LATENCY(3)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] sum;
      int          cyc;
      int          id;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cyc     = 0;
   int          n_chk   = 0;
   int          n_err   = 0;
   int          n_issue = 0;
   logic [31:0] last_sum = '0;

   // a, b, expected sum
   logic [31:0] tv [25][3] = '{
      '{32'h3F800000, 32'h40000000, 32'h40400000},
      '{32'h40400000, 32'h40FC0000, 32'h412E0000},
      '{32'hC0400000, 32'hC0000000, 32'hC0A00000},
      '{32'h40FC0000, 32'h3E400000, 32'h41010000},
      '{32'h40400000, 32'h3E400000, 32'h404C0000},
      '{32'h3F800000, 32'h00000000, 32'h3F800000},
      '{32'h3F800000, 32'hBF800000, 32'h00000000},
      '{32'h80000000, 32'h80000000, 32'h80000000},
      '{32'h00000000, 32'h80000000, 32'h00000000},
      '{32'h3F800000, 32'h33800000, 32'h3F800000},
      '{32'h3F800001, 32'h33800000, 32'h3F800002},
      '{32'h3F800000, 32'h33800001, 32'h3F800001},
      '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
      '{32'h7FC00000, 32'h3F800000, 32'h7FC00000},
      '{32'h3F800000, 32'h7FA00000, 32'h7FC00000},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
      '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
      '{32'hFF800000, 32'h3F800000, 32'hFF800000},
      '{32'h3F800000, 32'h7F800000, 32'h7F800000},
      '{32'h00400000, 32'h3F800000, 32'h3F800000},
      '{32'h00800001, 32'h80800000, 32'h00000000},
      '{32'h80800001, 32'h00800000, 32'h80000000},
      '{32'h3F800000, 32'h30800000, 32'h3F800000},
      '{32'h3F800000, 32'hB0800000, 32'h3F800000},
      '{32'h40000000, 32'hBF800000, 32'h3F800000}
   };

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xs);
      exp_t t;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a        = xa;
      bus.b        = xb;
      t.sum = xs;
      t.cyc = cyc + 1;
      t.id  = n_issue;
      sb.push_back(t);
      n_issue++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.a        = $urandom;
         bus.b        = $urandom;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      #2;
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor, sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               check("unexp_valid", 32'(bus.out_valid), 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check($sformatf("sum[%0d]", mon_e.id), bus.sum, mon_e.sum);
               check($sformatf("lat[%0d]", mon_e.id), 32'(cyc - mon_e.cyc), 32'd3);
               last_sum = mon_e.sum;
            end
         end else begin
            check("hold", bus.sum, last_sum);
         end
      end else begin
         last_sum = '0;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout n_chk=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.a        = '0;
      bus.b        = '0;

      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_sum", bus.sum, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Lone operation, then the rest back to back.
      issue(tv[0][0], tv[0][1], tv[0][2]);
      idle(6);
      for (int i = 1; i < $size(tv); i++) begin
         issue(tv[i][0], tv[i][1], tv[i][2]);
      end
      idle(1);
      drain();
      idle(3);

      // Reset while three operations are in flight.
      for (int i = 1; i < 4; i++) begin
         issue(tv[i][0], tv[i][1], tv[i][2]);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n        = 1'b0;
      @(posedge clk);
      #2;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_sum", bus.sum, 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      idle(10);

      // Pipeline is usable again after the flush.
      issue(tv[10][0], tv[10][1], tv[10][2]);
      idle(1);
      drain();
      idle(2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
